char_line_writer: RTL and testbench

- Sequences the registered nibble-to-character converter (numb2char) to render a row of NUM_CHARS 4-bit values into the character buffer feeding the VGA text overlay.
- Shares that single converter between two requesters, such as a score display and a status line, using round-robin arbitration.
- Per accepted request: issues one nibble per cycle to the converter, captures the resulting char code one cycle later, and writes it to base_addr+index.
- Sits beside a numb2char instance in the display subsystem; both are instantiated in the same parent.

---
 rtl/vga_pkg.sv | 14 +
 rtl/char_line_writer_rr_arbiter2.sv | 39 +++
 rtl/char_line_writer.sv | 131 +++++++++++++
 tb/tb_char_line_writer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA text-overlay display subsystem.
package vga_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_RUN   = 2'd1,
        WR_FLUSH = 2'd2
    } writer_state_e;

    // Nibble value that numb2char renders as a blank cell.
    localparam logic [3:0] CONV_IDLE_NUMB    = 4'hF;
    localparam int         DEFAULT_NUM_CHARS = 8;

endpackage

// File: rtl/char_line_writer_rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant and an internal last-grant pointer.
module rr_arbiter2
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q: 1 means requester 1 was granted last, so requester 0 wins a tie.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        last_d = last_q;
        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/char_line_writer.sv
// Renders a row of nibbles into the text-overlay character buffer through a shared,
// registered numb2char converter, arbitrating between two requesters.
module char_line_writer
    import vga_pkg::*;
#(
    parameter int NUM_CHARS = DEFAULT_NUM_CHARS,
    parameter int ADDR_W    = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [4*NUM_CHARS-1:0] numbs_0,
    input  logic [ADDR_W-1:0]      base_addr_0,
    input  logic [4*NUM_CHARS-1:0] numbs_1,
    input  logic [ADDR_W-1:0]      base_addr_1,
    output logic [1:0]             gnt,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             conv_numb,
    input  logic [6:0]             conv_char,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [6:0]             wr_data,
    output writer_state_e          dbg_state
);

    localparam int               IDX_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    writer_state_e          state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*NUM_CHARS-1:0] shadow_q, shadow_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [3:0]             conv_numb_q, conv_numb_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   arb_en;
    logic [1:0]             arb_gnt;

    // Grants are only offered while idle and never while reset is held.
    assign arb_en = (state_q == WR_IDLE) && rst_n;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req),
        .gnt   (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        base_d      = base_q;
        conv_numb_d = CONV_IDLE_NUMB;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            WR_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    shadow_d    = arb_gnt[1] ? numbs_1 : numbs_0;
                    base_d      = arb_gnt[1] ? base_addr_1 : base_addr_0;
                    idx_d       = '0;
                    conv_numb_d = shadow_d[3:0];
                    busy_d      = 1'b1;
                    state_d     = WR_RUN;
                end
            end
            WR_RUN: begin
                // The char for the nibble on conv_numb now arrives next cycle,
                // which is when this write strobe and address become visible.
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + ADDR_W'(idx_q);
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = WR_FLUSH;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    conv_numb_d = shadow_q[{idx_d, 2'b00} +: 4];
                end
            end
            WR_FLUSH: begin
                busy_d  = 1'b0;
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WR_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            base_q      <= '0;
            conv_numb_q <= CONV_IDLE_NUMB;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            base_q      <= base_d;
            conv_numb_q <= conv_numb_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = arb_gnt;
    assign busy      = busy_q;
    assign done      = done_q;
    assign conv_numb = conv_numb_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    // conv_char is already registered inside numb2char; gate it so idle cycles read zero.
    assign wr_data   = wr_en_q ? conv_char : 7'd0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_char_line_writer.sv
// Self-checking bench for char_line_writer with a behavioural numb2char in the loop.
module tb_char_line_writer;
    import vga_pkg::*;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int W  = AW + 7;

    localparam logic [N+1:0] BUSY_EXP = {1'b0, {(N+1){1'b1}}};
    localparam logic [N+1:0] DONE_EXP = {2'b01, {N{1'b0}}};
    localparam logic [N+1:0] WR_EXP   = {1'b0, {N{1'b1}}, 1'b0};

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      req = 2'b00;
    logic [4*N-1:0]  numbs_0 = '0;
    logic [4*N-1:0]  numbs_1 = '0;
    logic [AW-1:0]   base_addr_0 = '0;
    logic [AW-1:0]   base_addr_1 = '0;
    logic [1:0]      gnt;
    logic            busy, done, wr_en;
    logic [3:0]      conv_numb;
    logic [6:0]      conv_char;
    logic [AW-1:0]   wr_addr;
    logic [6:0]      wr_data;
    writer_state_e   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: which requester was granted last (1 after reset).
    logic model_last = 1'b1;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  obs_q[$];
    logic [N+1:0]  busy_m, done_m, wr_m;
    logic [1:0]    gnt_end, gnt_during;

    char_line_writer #(.NUM_CHARS(N), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .numbs_0     (numbs_0),
        .base_addr_0 (base_addr_0),
        .numbs_1     (numbs_1),
        .base_addr_1 (base_addr_1),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .conv_numb   (conv_numb),
        .conv_char   (conv_char),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural numb2char: 0..7 -> 'A'..'H', everything else -> SPACE.
    function automatic logic [6:0] n2c(input logic [3:0] n);
        return (n < 4'd8) ? (7'h41 + {3'b000, n}) : 7'h20;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conv_char <= 7'h20;
        else        conv_char <= n2c(conv_numb);
    end

    function automatic logic [1:0] model_winner(input logic [1:0] r);
        if (r == 2'b11) return model_last ? 2'b01 : 2'b10;
        return r;
    endfunction

    task automatic make_exp(input logic [4*N-1:0] nb, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            a = base + AW'(k);
            exp_q.push_back({a, n2c(nb[4*k +: 4])});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 40 && g == 2'b00; i++) begin
            @(negedge clk);
            g = gnt;
        end
    endtask

    // Records cycles T1..T(N+2) after a grant.
    task automatic capture_row();
        obs_q.delete();
        busy_m = '0; done_m = '0; wr_m = '0; gnt_during = 2'b00; gnt_end = 2'b00;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            busy_m[c-1] = busy;
            done_m[c-1] = done;
            wr_m[c-1]   = wr_en;
            if (wr_en) obs_q.push_back({wr_addr, wr_data});
            if (c <= N + 1) gnt_during = gnt_during | gnt;
            else            gnt_end = gnt;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({gnt, busy, done, wr_en, wr_addr, wr_data, conv_numb} !== {2'b00, 3'b000, 1'b0, 7'd0, 7'd0, 4'hF}) begin
            n_err++;
            $display("FAIL reset_hold: gnt/busy/done/wr_en/addr/data/numb got %b/%b/%b/%b/%0d/%h/%h", gnt, busy, done, wr_en, wr_addr, wr_data, conv_numb);
        end
        step();
        rst_n = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt, busy, done, wr_en, conv_numb} !== {2'b00, 3'b000, 4'hF}) begin
                n_err++;
                $display("FAIL reset_idle: gnt/busy/done/wr_en/numb got %b/%b/%b/%b/%h want 00/0/0/0/f", gnt, busy, done, wr_en, conv_numb);
            end
        end
    endtask

    task automatic test_single();
        logic [1:0] g, eg;
        step();
        numbs_0 = 16'h3210; base_addr_0 = 7'd10; req = 2'b01;
        eg = model_winner(req);
        wait_gnt(g);
        n_cmp++;
        if (g !== eg) begin n_err++; $display("FAIL single gnt: got %b want %b", g, eg); end
        model_last = eg[1];
        step();
        req = 2'b00;
        capture_row();
        make_exp(16'h3210, 7'd10);
        n_cmp++;
        if ({busy_m, done_m, wr_m} !== {BUSY_EXP, DONE_EXP, WR_EXP}) begin
            n_err++;
            $display("FAIL single timing: busy/done/wr got %b/%b/%b want %b/%b/%b", busy_m, done_m, wr_m, BUSY_EXP, DONE_EXP, WR_EXP);
        end
        foreach (exp_q[i]) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL single write %0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] g, eg;
        logic [4*N-1:0] n0, n1;
        logic [AW-1:0] b0, b1;
        n0 = 16'($urandom_range(0, 16'hFFFF)); n1 = 16'($urandom_range(0, 16'hFFFF));
        b0 = 7'($urandom_range(0, 127));       b1 = 7'($urandom_range(0, 127));
        step();
        rst_n = 1'b0; req = 2'b11;
        numbs_0 = n0; numbs_1 = n1; base_addr_0 = b0; base_addr_1 = b1;
        model_last = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gnt !== 2'b00) begin n_err++; $display("FAIL contention gnt_in_reset: got %b want 00", gnt); end
        step();
        rst_n = 1'b1;
        wait_gnt(g);
        eg = model_winner(2'b11);
        n_cmp++;
        if (g !== eg) begin n_err++; $display("FAIL contention first gnt: got %b want %b", g, eg); end
        model_last = eg[1];
        for (int round = 0; round < 3; round++) begin
            if (round == 2) begin step(); req = 2'b00; end
            capture_row();
            if (eg[1]) make_exp(n1, b1); else make_exp(n0, b0);
            n_cmp++;
            if ({busy_m, done_m, wr_m} !== {BUSY_EXP, DONE_EXP, WR_EXP}) begin
                n_err++;
                $display("FAIL contention r%0d timing: busy/done/wr got %b/%b/%b", round, busy_m, done_m, wr_m);
            end
            foreach (exp_q[i]) begin
                n_cmp++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL contention r%0d write %0d: got %h want %h", round, i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]);
                end
            end
            eg = (round < 1) ? model_winner(2'b11) : (round == 1 ? model_winner(2'b11) : 2'b00);
            n_cmp++;
            if (gnt_end !== eg) begin n_err++; $display("FAIL contention r%0d next gnt: got %b want %b", round, gnt_end, eg); end
            if (eg != 2'b00) model_last = eg[1];
        end
    endtask

    task automatic test_wrap();
        logic [1:0] g;
        step();
        numbs_1 = 16'h9876; base_addr_1 = 7'd126; req = 2'b10;
        wait_gnt(g);
        n_cmp++;
        if (g !== model_winner(2'b10)) begin n_err++; $display("FAIL wrap gnt: got %b want 10", g); end
        model_last = 1'b1;
        step();
        req = 2'b00;
        capture_row();
        make_exp(16'h9876, 7'd126);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL wrap write %0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] g, eg;
        logic [4*N-1:0] nb;
        logic [AW-1:0] b;
        step();
        numbs_0 = 16'($urandom_range(0, 16'hFFFF)); base_addr_0 = 7'($urandom_range(0, 127)); req = 2'b01;
        wait_gnt(g);
        n_cmp++;
        if (g !== 2'b01) begin n_err++; $display("FAIL midreset first gnt: got %b want 01", g); end
        model_last = 1'b0;
        step();
        req = 2'b00;
        repeat (3) @(negedge clk);
        step();
        rst_n = 1'b0;
        model_last = 1'b1;
        #1;
        n_cmp++;
        if ({wr_en, busy, done, gnt, conv_numb, wr_addr, wr_data} !== {3'b000, 2'b00, 4'hF, 7'd0, 7'd0}) begin
            n_err++;
            $display("FAIL midreset async: wr_en/busy/done/gnt/numb/addr/data got %b/%b/%b/%b/%h/%0d/%h", wr_en, busy, done, gnt, conv_numb, wr_addr, wr_data);
        end
        nb = 16'($urandom_range(0, 16'hFFFF)); b = 7'($urandom_range(0, 127));
        step();
        rst_n = 1'b1; req = 2'b11; numbs_0 = nb; base_addr_0 = b;
        eg = model_winner(2'b11);
        wait_gnt(g);
        n_cmp++;
        if (g !== eg) begin n_err++; $display("FAIL midreset rearb gnt: got %b want %b", g, eg); end
        model_last = eg[1];
        step();
        req = 2'b00;
        capture_row();
        make_exp(nb, b);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midreset restart write %0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]);
            end
        end
    endtask

    task automatic test_dropped();
        logic [1:0] g;
        logic [4*N-1:0] nb;
        logic [AW-1:0] b;
        nb = 16'($urandom_range(0, 16'hFFFF)); b = 7'($urandom_range(0, 127));
        step();
        numbs_0 = nb; base_addr_0 = b; req = 2'b01;
        wait_gnt(g);
        n_cmp++;
        if (g !== 2'b01) begin n_err++; $display("FAIL dropped gnt0: got %b want 01", g); end
        model_last = 1'b0;
        step();
        req = 2'b00;
        numbs_0 = ~nb;
        base_addr_0 = b + 7'd33;
        fork
            capture_row();
            begin
                step(); req = 2'b10;
                step();
                step(); req = 2'b00;
            end
        join
        make_exp(nb, b);
        n_cmp++;
        if ({gnt_during, gnt_end} !== 4'b0000) begin
            n_err++;
            $display("FAIL dropped stray gnt: during/end got %b/%b want 00/00", gnt_during, gnt_end);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL dropped write count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_cmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL dropped shadow write %0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({gnt, wr_en, busy} !== 4'b0000) begin
                n_err++;
                $display("FAIL dropped idle: gnt/wr_en/busy got %b/%b/%b want 00/0/0", gnt, wr_en, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] r, g, eg;
        for (int round = 0; round < 8; round++) begin
            step();
            r = 2'($urandom_range(1, 3));
            numbs_0 = 16'($urandom_range(0, 16'hFFFF)); numbs_1 = 16'($urandom_range(0, 16'hFFFF));
            base_addr_0 = 7'($urandom_range(0, 127));   base_addr_1 = 7'($urandom_range(0, 127));
            req = r;
            eg = model_winner(r);
            wait_gnt(g);
            n_cmp++;
            if (g !== eg) begin n_err++; $display("FAIL random r%0d gnt: req %b got %b want %b", round, r, g, eg); end
            model_last = eg[1];
            if (eg[1]) make_exp(numbs_1, base_addr_1); else make_exp(numbs_0, base_addr_0);
            step();
            req = 2'b00;
            capture_row();
            n_cmp++;
            if ({busy_m, done_m, wr_m} !== {BUSY_EXP, DONE_EXP, WR_EXP}) begin
                n_err++;
                $display("FAIL random r%0d timing: busy/done/wr got %b/%b/%b", round, busy_m, done_m, wr_m);
            end
            foreach (exp_q[i]) begin
                n_cmp++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL random r%0d write %0d: got %h want %h", round, i, (i < obs_q.size()) ? obs_q[i] : {W{1'bx}}, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_mid_reset();
        test_dropped();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
